goc_tx_arbiter: RTL and testbench
=================================

GOC_TX_ARBITER -- requirements
Module: goc_tx_arbiter

Interface
REQ-001 Parameter GAP_W, default 16: width of the inter-frame gap count.
REQ-002 Parameter TO_W, default 22: width of the transmit stall timeout count.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  when low, no new grant is issued; a frame already in progress completes.
REQ-006 gap_cycles  input  GAP_W  idle cycles enforced between frames.
REQ-007 timeout_cycles  input  TO_W  maximum cycles without tx_re while transmitting; 0 disables the timeout.
REQ-008 r0_data, r1_data  input  9 each  requester character (bit 8 = tail flag, passed through untouched).
REQ-009 r0_valid, r1_valid  input  1 each  requester has a frame or character pending (level).
REQ-010 r0_next, r1_next  output  1 each  read strobe to the requester.
REQ-011 tx_data  output  9  character to the GOC PWM transmitter.
REQ-012 tx_empty  output  1  transmitter FIFO-empty indication.
REQ-013 tx_re  input  1  transmitter read enable.
REQ-014 tx_start  output  1  one-cycle start pulse to the transmitter.
REQ-015 grant  output  2  one-hot owner of the transmitter (bit n = requester n).
REQ-016 done  output  2  one-cycle pulse: requester n's frame completed normally.
REQ-017 err  output  2  one-cycle pulse: requester n's frame was aborted by the timeout.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 The block SHALL implement the states IDLE, START, TX and GAP.
REQ-020 IDLE: when enable=1 and any rN_valid=1, the block SHALL register grant for the winner and go to START; otherwise it SHALL stay in IDLE with grant=0.
REQ-021 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred requester; the other requester wins only if the preferred one is not valid.
REQ-022 The pointer SHALL be set to the non-served requester on every exit from TX (both done and err).
REQ-023 START SHALL last exactly one cycle with tx_start=1 and then go to TX; tx_start SHALL be 0 in all other states.
REQ-024 In START and TX: tx_data = rN_data of the granted requester, tx_empty = ~rN_valid of the granted requester, rN_next = tx_re & grant[N]; the non-granted requester's next SHALL be 0.
REQ-025 Outside START/TX: tx_empty=1, tx_data=0, r0_next=r1_next=0.
REQ-026 TX: when the granted rN_valid=0, the block SHALL pulse done[N] for one cycle, load the gap counter with gap_cycles and go to GAP.
REQ-027 Stall counter (TO_W bits): cleared on entry to TX and on each cycle with tx_re=1, otherwise incremented; it SHALL saturate and never wrap.
REQ-028 If timeout_cycles!=0 and the stall counter equals timeout_cycles while the granted valid is still 1, the block SHALL pulse err[N] and go to GAP. The block SHALL NOT drain the requester.
REQ-029 If valid drops in the same cycle as the timeout, done SHALL take precedence and err SHALL stay 0.
REQ-030 GAP: grant=0; the counter decrements each cycle; the block SHALL return to IDLE in the cycle after the count is 0, so gap_cycles=0 gives one GAP cycle and gap_cycles=G gives G+1 cycles.
REQ-031 A change of enable, gap_cycles or timeout_cycles mid-frame SHALL NOT affect the current frame, except that timeout_cycles is compared live.
REQ-032 rN_valid deasserting in IDLE before the grant is issued SHALL cause no grant.

Reset
REQ-033 While reset=1, the block SHALL force state=IDLE, grant=0, tx_start=0, done=0, err=0, busy=0, pointer=0 (requester 0 preferred), and clear the stall and gap counters.
REQ-034 Reset asserted mid-frame SHALL immediately release grant and emit neither done nor err.

Verification
REQ-035 Single frame: r0 supplies 4 characters, gap_cycles=3 -> grant=01, tx_start pulses once, exactly 4 r0_next pulses aligned to tx_re, done[0] pulses once, 4 GAP cycles, then IDLE.
REQ-036 Contention: r0_valid and r1_valid both held high from reset -> service order r0, r1, r0, r1, with no overlap of grant bits.
REQ-037 Timeout: timeout_cycles=10, tx_re held low after START -> err[granted] pulses 10 cycles after TX entry, done stays 0, and the pointer moves to the other requester.
REQ-038 Disable: enable=0 while r1_valid=1 -> no grant; enable=0 mid-frame -> the frame finishes with done, then no new grant is issued.
REQ-039 Async reset asserted in TX between clock edges -> grant=0 and busy=0 before the next edge, no done or err pulse, and requester 0 is preferred afterwards.
REQ-040 Corner case: valid drop coinciding with the timeout -> done=1, err=0; gap_cycles=0 -> exactly one GAP cycle.

Source files
------------

// File: rtl/goc_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a GOC PWM transmitter.
// Handles frame ownership, stall timeout and the enforced inter-frame gap.
module goc_tx_arbiter #(
    parameter int unsigned GAP_W = 16,
    parameter int unsigned TO_W  = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [TO_W-1:0]    timeout_cycles,
    input  logic [8:0]         r0_data,
    input  logic [8:0]         r1_data,
    input  logic               r0_valid,
    input  logic               r1_valid,
    output logic               r0_next,
    output logic               r1_next,
    output logic [8:0]         tx_data,
    output logic               tx_empty,
    input  logic               tx_re,
    output logic               tx_start,
    output logic [1:0]         grant,
    output logic [1:0]         done,
    output logic [1:0]         err,
    output logic               busy
);

    localparam logic [TO_W-1:0] STALL_MAX = {TO_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_TX,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               ptr_q, ptr_d;
    logic [TO_W-1:0]    stall_q, stall_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               tx_start_q, tx_start_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               busy_q, busy_d;

    logic               pref_valid;
    logic               win;
    logic               gsel;
    logic               gvalid;
    logic               active;

    // Arbitration and granted-requester selection
    always_comb begin
        pref_valid = ptr_q ? r1_valid : r0_valid;
        win        = pref_valid ? ptr_q : ~ptr_q;
        gsel       = grant_q[1];
        gvalid     = gsel ? r1_valid : r0_valid;
        active     = (state_q == ST_START) || (state_q == ST_TX);
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        stall_d    = stall_q;
        gap_d      = gap_q;
        tx_start_d = 1'b0;
        done_d     = 2'b00;
        err_d      = 2'b00;

        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (enable && (r0_valid || r1_valid)) begin
                    grant_d    = win ? 2'b10 : 2'b01;
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                stall_d = '0;
                state_d = ST_TX;
            end
            ST_TX: begin
                // A drained requester wins over a simultaneous timeout
                if (!gvalid) begin
                    done_d  = grant_q;
                    gap_d   = gap_cycles;
                    ptr_d   = ~gsel;
                    grant_d = 2'b00;
                    state_d = ST_GAP;
                end else if ((timeout_cycles != '0) && (stall_q == timeout_cycles)) begin
                    err_d   = grant_q;
                    gap_d   = gap_cycles;
                    ptr_d   = ~gsel;
                    grant_d = 2'b00;
                    state_d = ST_GAP;
                end else if (tx_re) begin
                    stall_d = '0;
                end else if (stall_q != STALL_MAX) begin
                    stall_d = stall_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 2'b00;
            ptr_q      <= 1'b0;
            stall_q    <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            stall_q    <= stall_d;
            gap_q      <= gap_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    // Transmitter-facing datapath follows the current owner while a frame is live
    assign tx_data  = active ? (gsel ? r1_data : r0_data) : 9'd0;
    assign tx_empty = active ? ~gvalid : 1'b1;
    assign r0_next  = active & tx_re & grant_q[0];
    assign r1_next  = active & tx_re & grant_q[1];

    assign tx_start = tx_start_q;
    assign grant    = grant_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_goc_tx_arbiter.sv
// Bench for goc_tx_arbiter: per-cycle comparison against a frame-level model
// plus directed scenarios with hand-computed event counts and timings.
module tb_goc_tx_arbiter;

    localparam int unsigned GAP_W = 16;
    localparam int unsigned TO_W  = 22;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [GAP_W-1:0] gap_cycles;
    logic [TO_W-1:0]  timeout_cycles;
    logic [8:0]       r0_data, r1_data;
    logic             r0_valid, r1_valid, r0_next, r1_next;
    logic [8:0]       tx_data;
    logic             tx_empty, tx_re, tx_start, busy;
    logic [1:0]       grant, done, err;

    logic hold0, hold1, re_en;
    int   avail0, avail1;
    int   cons0 = 0;
    int   cons1 = 0;

    int tests = 0;
    int fails = 0;

    goc_tx_arbiter #(.GAP_W(GAP_W), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
        .r0_data(r0_data), .r1_data(r1_data),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_next(r0_next), .r1_next(r1_next),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_re(tx_re),
        .tx_start(tx_start), .grant(grant), .done(done), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Requesters: a character source that advances on each read strobe
    assign r0_valid = hold0 | (avail0 > cons0);
    assign r1_valid = hold1 | (avail1 > cons1);
    assign r0_data  = {(avail0 - cons0 == 1), 8'(cons0 + 64)};
    assign r1_data  = {(avail1 - cons1 == 1), 8'(cons1 + 200)};
    assign tx_re    = re_en & ~tx_empty;

    always @(posedge clk) begin
        if (r0_next) cons0 <= cons0 + 1;
        if (r1_next) cons1 <= cons1 + 1;
    end

    // Inputs as seen by the DUT at the last rising edge
    logic             s_reset = 1'b1;
    logic             s_en = 1'b0;
    logic             s_re = 1'b0;
    logic [1:0]       s_v = 2'b00;
    int               s_gap = 0;
    int               s_to = 0;

    always @(posedge clk) begin
        s_reset <= reset;
        s_en    <= enable;
        s_re    <= tx_re;
        s_v     <= {r1_valid, r0_valid};
        s_gap   <= int'(gap_cycles);
        s_to    <= int'(timeout_cycles);
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state: phase 0=idle 1=start 2=transmit 3=gap
    int         m_phase = 0, m_owner = 0, m_pref = 0, m_stall = 0, m_gap = 0;
    logic [1:0] m_done = 2'b00, m_err = 2'b00;

    // Observed event log
    int cyc = 0, n_start = 0, n_gap = 0, start_cyc = 0, err_cyc = 0;
    int n_next[2], n_done[2], n_err[2];
    int owners[$];

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_pref = 0; m_stall = 0; m_gap = 0;
        m_done = 2'b00; m_err = 2'b00;
    endtask

    task automatic end_frame();
        m_gap   = s_gap;
        m_pref  = 1 - m_owner;
        m_phase = 3;
    endtask

    task automatic model_step();
        m_done = 2'b00;
        m_err  = 2'b00;
        case (m_phase)
            0: if (s_en && s_v != 2'b00) begin
                   m_owner = s_v[m_pref] ? m_pref : 1 - m_pref;
                   m_phase = 1;
               end
            1: begin m_phase = 2; m_stall = 0; end
            2: if (!s_v[m_owner]) begin
                   m_done[m_owner] = 1'b1;
                   end_frame();
               end else if (s_to != 0 && m_stall == s_to) begin
                   m_err[m_owner] = 1'b1;
                   end_frame();
               end else begin
                   m_stall = s_re ? 0 : ((m_stall < (1 << TO_W) - 1) ? m_stall + 1 : m_stall);
               end
            default: if (m_gap == 0) m_phase = 0; else m_gap = m_gap - 1;
        endcase
    endtask

    initial begin
        bit         act;
        logic [8:0] e_data;
        n_next = '{0, 0}; n_done = '{0, 0}; n_err = '{0, 0};
        forever begin
            @(negedge clk);
            cyc++;
            if (s_reset) model_reset(); else model_step();
            if (reset) model_reset();
            act    = (m_phase == 1) || (m_phase == 2);
            e_data = act ? (m_owner == 1 ? r1_data : r0_data) : 9'd0;
            chk("grant",    int'(grant),    act ? (1 << m_owner) : 0);
            chk("tx_start", int'(tx_start), int'(m_phase == 1));
            chk("busy",     int'(busy),     int'(m_phase != 0));
            chk("done",     int'(done),     int'(m_done));
            chk("err",      int'(err),      int'(m_err));
            chk("tx_data",  int'(tx_data),  int'(e_data));
            chk("tx_empty", int'(tx_empty), act ? int'(!(m_owner == 1 ? r1_valid : r0_valid)) : 1);
            chk("r0_next",  int'(r0_next),  int'(act && m_owner == 0 && tx_re));
            chk("r1_next",  int'(r1_next),  int'(act && m_owner == 1 && tx_re));
            if (tx_start) begin
                n_start++;
                owners.push_back(grant[1] ? 1 : 0);
                start_cyc = cyc;
            end
            if (r0_next) n_next[0]++;
            if (r1_next) n_next[1]++;
            if (done[0]) n_done[0]++;
            if (done[1]) n_done[1]++;
            if (err[0]) n_err[0]++;
            if (err[1]) n_err[1]++;
            if (err != 2'b00) err_cyc = cyc;
            if (busy && grant == 2'b00) n_gap++;
        end
    end

    int b_start, b_gap, b_own;
    int b_next[2], b_done[2], b_err[2];

    task automatic base();
        b_start = n_start; b_gap = n_gap; b_own = owners.size();
        b_next = n_next; b_done = n_done; b_err = n_err;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input logic val, input int max, input string nm);
        int k = 0;
        while (busy !== val && k < max) begin
            tick();
            k++;
        end
        chk(nm, int'(busy), int'(val));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; gap_cycles = 16'd3; timeout_cycles = '0;
        hold0 = 1'b0; hold1 = 1'b0; re_en = 1'b0; avail0 = 0; avail1 = 0;
        repeat (3) tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_empty", int'(tx_empty), 1);
        reset = 1'b0;
        tick();

        // Single 4-character frame from r0, gap of 3
        base();
        enable = 1'b1; re_en = 1'b1; avail0 = cons0 + 4;
        wait_busy(1'b1, 10, "s1_start_to");
        wait_busy(1'b0, 50, "s1_end_to");
        chk("s1_starts", n_start - b_start, 1);
        chk("s1_owner", owners[b_own], 0);
        chk("s1_next0", n_next[0] - b_next[0], 4);
        chk("s1_next1", n_next[1] - b_next[1], 0);
        chk("s1_done0", n_done[0] - b_done[0], 1);
        chk("s1_err", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]), 0);
        chk("s1_gap_cycles", n_gap - b_gap, 4);

        // Disabled: pending r1 gets no grant
        base();
        enable = 1'b0; avail1 = cons1 + 2;
        repeat (6) tick();
        chk("s2_no_grant_busy", int'(busy), 0);
        chk("s2_no_start", n_start - b_start, 0);

        // Enable drops mid-frame: frame completes, waiting r0 not served
        base();
        avail1 = cons1 + 6; enable = 1'b1;
        wait_busy(1'b1, 10, "s2_start_to");
        tick();
        enable = 1'b0; avail0 = cons0 + 2;
        wait_busy(1'b0, 60, "s2_end_to");
        repeat (5) tick();
        chk("s2_done1", n_done[1] - b_done[1], 1);
        chk("s2_starts", n_start - b_start, 1);
        chk("s2_next1", n_next[1] - b_next[1], 6);
        chk("s2_next0", n_next[0] - b_next[0], 0);
        chk("s2_idle", int'(busy), 0);
        base();
        enable = 1'b1;
        wait_busy(1'b1, 10, "s2b_start_to");
        wait_busy(1'b0, 60, "s2b_end_to");
        chk("s2b_done0", n_done[0] - b_done[0], 1);
        chk("s2b_owner", owners[b_own], 0);

        // Timeout of 10 with no reads; pointer then favours r1
        base();
        timeout_cycles = 22'd10; re_en = 1'b0; gap_cycles = 16'd2; hold0 = 1'b1;
        begin
            int k = 0;
            while (n_err[0] + n_err[1] == b_err[0] + b_err[1] && k < 40) begin
                tick();
                k++;
            end
        end
        chk("s3_err0", n_err[0] - b_err[0], 1);
        chk("s3_done", (n_done[0] - b_done[0]) + (n_done[1] - b_done[1]), 0);
        chk("s3_err_latency", err_cyc - start_cyc, 12);
        chk("s3_owner", owners[b_own], 0);
        hold1 = 1'b1;
        begin
            int k = 0;
            while (n_start - b_start < 2 && k < 40) begin
                tick();
                k++;
            end
        end
        chk("s3_next_owner", owners[owners.size() - 1], 1);
        hold0 = 1'b0; hold1 = 1'b0;
        wait_busy(1'b0, 60, "s3_end_to");

        // Asynchronous reset during transmission
        base();
        timeout_cycles = '0; re_en = 1'b1; hold1 = 1'b1;
        wait_busy(1'b1, 10, "s5_start_to");
        repeat (3) tick();
        chk("s5_grant_tx", int'(grant), 2);
        reset = 1'b1;
        #1;
        chk("s5_grant_rel", int'(grant), 0);
        chk("s5_busy_rel", int'(busy), 0);
        hold1 = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("s5_no_done", (n_done[0] - b_done[0]) + (n_done[1] - b_done[1]), 0);
        chk("s5_no_err", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]), 0);

        // Contention from reset: r0, r1, r0, r1
        base();
        timeout_cycles = 22'd4; re_en = 1'b0; gap_cycles = 16'd1;
        hold0 = 1'b1; hold1 = 1'b1;
        begin
            int k = 0;
            while (n_start - b_start < 4 && k < 200) begin
                tick();
                k++;
            end
        end
        chk("s4_starts", n_start - b_start, 4);
        hold0 = 1'b0; hold1 = 1'b0;
        wait_busy(1'b0, 60, "s4_end_to");
        for (int i = 0; i < 4; i++) begin
            if (b_own + i < owners.size()) chk("s4_order", owners[b_own + i], i % 2);
            else chk("s4_order_missing", owners.size() - b_own, 4);
        end
        chk("s4_err0", n_err[0] - b_err[0], 2);
        chk("s4_err1", n_err[1] - b_err[1], 1);

        // Valid drop coinciding with the timeout, gap of 0
        base();
        timeout_cycles = 22'd3; gap_cycles = 16'd0; re_en = 1'b0; hold0 = 1'b1;
        repeat (5) tick();
        hold0 = 1'b0;
        wait_busy(1'b0, 20, "s6_end_to");
        chk("s6_done0", n_done[0] - b_done[0], 1);
        chk("s6_err", (n_err[0] - b_err[0]) + (n_err[1] - b_err[1]), 0);
        chk("s6_gap_cycles", n_gap - b_gap, 1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
